clk_ena_divider_bank: RTL

//  Parametrised clock-enable generator fed by the PLL fast clock (e.g. 6x 7.09 MHz = 42.56 MHz).

---
 rtl/clk_ena_divider_bank_if.sv | 38 +++
 rtl/clk_ena_divider_bank.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/clk_ena_divider_bank_if.sv
// ---------------------------------------------------------------------------
// clk_ena_divider_bank_if
//   Bundles the control inputs and enable outputs of clk_ena_divider_bank.
//   All signals belong to the clkin domain.
//
//   pll_lock   PLL lock, already synchronised to clkin
//   sync       one-cycle realign pulse for all channels
//   div_wr     per-channel ratio write strobe
//   div_wdata  ratio written to every channel whose strobe is set
//   cken       one-cycle clock enable per channel
//   cphase     50% phase flag per channel, toggles on each cken
//   ready      high while the bank is running
//
//   master: drives the controls (system / testbench side)
//   slave : the divider bank itself
// ---------------------------------------------------------------------------
interface clk_ena_divider_bank_if #(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 8
);
    logic              pll_lock;
    logic              sync;
    logic [NUM_CH-1:0] div_wr;
    logic [DIV_W-1:0]  div_wdata;
    logic [NUM_CH-1:0] cken;
    logic [NUM_CH-1:0] cphase;
    logic              ready;

    modport master (
        output pll_lock, sync, div_wr, div_wdata,
        input  cken, cphase, ready
    );

    modport slave (
        input  pll_lock, sync, div_wr, div_wdata,
        output cken, cphase, ready
    );
endinterface

// File: rtl/clk_ena_divider_bank.sv
// ---------------------------------------------------------------------------
// clk_ena_divider_bank
//   Bank of NUM_CH runtime-programmable clock-enable dividers running on the
//   fast PLL clock. Each channel emits a one-cycle enable every Neff cycles
//   (Neff = N, or 1 when N == 0) and a phase flag that toggles on each enable,
//   giving a clkin/(2*Neff) square. Outputs stay low until pll_lock has been
//   high for LOCK_CYCLES consecutive cycles.
//
//   Ports
//     clkin   fast PLL clock, all logic on its rising edge
//     reset   synchronous, active-high
//     bus     slave side of clk_ena_divider_bank_if
//             (pll_lock, sync, div_wr, div_wdata in; cken, cphase, ready out)
//
//   Ratio handling: each channel holds a shadow ratio (last written value)
//   and an active ratio (the one timing the current period). While running,
//   active is refreshed from shadow only on a wrap or a sync, so a period in
//   progress is never shortened or stretched.
// ---------------------------------------------------------------------------
module clk_ena_divider_bank #(
    parameter int                      NUM_CH      = 3,
    parameter int                      DIV_W       = 8,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT    = {8'd3, 8'd2, 8'd6},
    parameter int                      LOCK_CYCLES = 1024
) (
    input  logic                  clkin,
    input  logic                  reset,
    clk_ena_divider_bank_if.slave bus
);

    localparam int              LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCW-1:0]  LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    // Terminal count for a ratio: a ratio of 0 behaves as 1, so the counter
    // never has to reach 2^DIV_W.
    function automatic logic [DIV_W-1:0] last_count(input logic [DIV_W-1:0] ratio);
        if (ratio == '0) begin
            return '0;
        end
        return ratio - 1'b1;
    endfunction

    state_t            state;
    state_t            state_next;
    logic [LCW-1:0]    lock_cnt;
    logic [LCW-1:0]    lock_cnt_next;
    logic              ready;

    logic [DIV_W-1:0]  cnt        [NUM_CH];
    logic [DIV_W-1:0]  active     [NUM_CH];
    logic [DIV_W-1:0]  shadow     [NUM_CH];
    logic [DIV_W-1:0]  shadow_next[NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] cken;
    logic [NUM_CH-1:0] cphase;

    logic              run_hold;
    logic              realign;

    // ---- lock qualification FSM: next state ----
    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        case (state)
            IDLE: begin
                if (bus.pll_lock) begin
                    state_next    = SETTLE;
                    lock_cnt_next = '0;
                end
            end
            SETTLE: begin
                if (!bus.pll_lock) begin
                    state_next = IDLE;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_next = RUN;
                end else begin
                    lock_cnt_next = lock_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!bus.pll_lock) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Channels only advance while running with lock still present; a lock
    // loss on the same edge as sync wins because realign requires run_hold.
    assign run_hold = (state == RUN) && bus.pll_lock;
    assign realign  = run_hold && bus.sync;

    // ---- per-channel shadow update and wrap detect ----
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_next[i] = bus.div_wr[i] ? bus.div_wdata : shadow[i];
            wrap[i]        = (cnt[i] == last_count(active[i]));
        end
    end

    // ---- registered state, counters and outputs ----
    always_ff @(posedge clkin) begin
        if (reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
            ready    <= 1'b0;
            cken     <= '0;
            cphase   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                active[i] <= DIV_INIT[i*DIV_W +: DIV_W];
                shadow[i] <= DIV_INIT[i*DIV_W +: DIV_W];
            end
        end else begin
            state    <= state_next;
            lock_cnt <= lock_cnt_next;
            ready    <= (state_next == RUN);
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= shadow_next[i];
                if (!run_hold || realign) begin
                    // Idle, lock loss or realign: park at count 0 with the
                    // latest ratio so the next RUN cycle starts a full period.
                    cnt[i]    <= '0;
                    cken[i]   <= 1'b0;
                    cphase[i] <= 1'b0;
                    active[i] <= shadow_next[i];
                end else if (wrap[i]) begin
                    cnt[i]    <= '0;
                    cken[i]   <= 1'b1;
                    cphase[i] <= ~cphase[i];
                    active[i] <= shadow_next[i];
                end else begin
                    cnt[i]    <= cnt[i] + 1'b1;
                    cken[i]   <= 1'b0;
                end
            end
        end
    end

    assign bus.cken   = cken;
    assign bus.cphase = cphase;
    assign bus.ready  = ready;

endmodule
